adma_as_atx_dispatch: RTL and testbench

AXI address-phase dispatcher placed directly downstream of the DMA transaction fetch/splitter stage. It accepts one combined AXI transaction descriptor per handshake and forks it into independent AR and AW master channels. It bounds the number of write bursts awaiting a B response. It retires B responses in order and pulses a per-DMA-transaction completion/error indication when the last burst of a DMA transaction is acknowledged.

---
 rtl/adma_as_atx_dispatch.sv | 207 ++++++++++++++++++++
 tb/tb_adma_as_atx_dispatch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_as_atx_dispatch.sv
// adma_as_atx_dispatch
//
// Address-phase dispatcher sitting behind the DMA transaction splitter.
// Each accepted descriptor is forked into an AR and an AW master request,
// each held in its own output register until its handshake completes.
// Write bursts that have been accepted but not yet acknowledged on B are
// bounded by MAX_OUTST. B responses retire in order, and when the last
// burst of a DMA transaction is acknowledged a one-cycle tx_done pulse is
// produced, with tx_err flagging any SLVERR/DECERR seen in that transaction.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   arid/araddr/arlen/arburst      read burst descriptor fields
//   awid/awaddr/awlen/awburst      write burst descriptor fields
//   atx_last                       burst closes its DMA transaction
//   atx_vld / atx_rdy              descriptor handshake
//   m_ar* / m_arvalid / m_arready  AXI AR master channel
//   m_aw* / m_awvalid / m_awready  AXI AW master channel
//   m_bresp / m_bvalid / m_bready  AXI B channel
//   tx_done / tx_err               per-transaction completion pulse and error

module adma_as_atx_dispatch #(
    parameter int SRC_ADDR_W = 32,
    parameter int DST_ADDR_W = 32,
    parameter int MST_ID_W   = 5,
    parameter int ATX_LEN_W  = 8,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MST_ID_W-1:0]   arid,
    input  logic [SRC_ADDR_W-1:0] araddr,
    input  logic [ATX_LEN_W-1:0]  arlen,
    input  logic [1:0]            arburst,
    input  logic [MST_ID_W-1:0]   awid,
    input  logic [DST_ADDR_W-1:0] awaddr,
    input  logic [ATX_LEN_W-1:0]  awlen,
    input  logic [1:0]            awburst,
    input  logic                  atx_last,
    input  logic                  atx_vld,
    output logic                  atx_rdy,
    output logic [MST_ID_W-1:0]   m_arid,
    output logic [SRC_ADDR_W-1:0] m_araddr,
    output logic [ATX_LEN_W-1:0]  m_arlen,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [MST_ID_W-1:0]   m_awid,
    output logic [DST_ADDR_W-1:0] m_awaddr,
    output logic [ATX_LEN_W-1:0]  m_awlen,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic                  tx_done,
    output logic                  tx_err
);

    localparam int OUTST_W = $clog2(MAX_OUTST + 1);
    // The last-flag FIFO is sized to the full index range of the outstanding
    // counter so it can be indexed directly by it; only the lowest MAX_OUTST
    // entries ever hold live flags.
    localparam int FIFO_N  = 1 << OUTST_W;

    logic [MST_ID_W-1:0]   arid_q,    arid_d;
    logic [SRC_ADDR_W-1:0] araddr_q,  araddr_d;
    logic [ATX_LEN_W-1:0]  arlen_q,   arlen_d;
    logic [1:0]            arburst_q, arburst_d;
    logic                  ar_pend_q, ar_pend_d;

    logic [MST_ID_W-1:0]   awid_q,    awid_d;
    logic [DST_ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic [ATX_LEN_W-1:0]  awlen_q,   awlen_d;
    logic [1:0]            awburst_q, awburst_d;
    logic                  aw_pend_q, aw_pend_d;

    logic [OUTST_W-1:0]    outst_cnt_q, outst_cnt_d;
    logic [FIFO_N-1:0]     fifo_q,      fifo_d;
    logic                  err_acc_q,   err_acc_d;
    logic                  tx_done_q,   tx_done_d;
    logic                  tx_err_q,    tx_err_d;

    logic                  ar_free;
    logic                  aw_free;
    logic                  below_lim;
    logic                  accept;
    logic                  b_hs;
    logic                  err_e;
    logic [OUTST_W-1:0]    push_idx;
    logic                  unused_bresp0;

    assign unused_bresp0 = m_bresp[0];

    assign ar_free   = ~ar_pend_q | m_arready;
    assign aw_free   = ~aw_pend_q | m_awready;
    assign below_lim = outst_cnt_q < OUTST_W'(MAX_OUTST);
    assign atx_rdy   = ar_free & aw_free & below_lim;
    assign accept    = atx_vld & atx_rdy;
    assign m_bready  = (outst_cnt_q != '0);
    assign b_hs      = m_bvalid & m_bready;
    assign err_e     = err_acc_q | m_bresp[1];
    // On a simultaneous pop the queue shifts down first, so the new flag
    // lands one slot lower.
    assign push_idx  = outst_cnt_q - OUTST_W'(b_hs);

    always_comb begin
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arburst_d   = arburst_q;
        ar_pend_d   = ar_pend_q;
        awid_d      = awid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awburst_d   = awburst_q;
        aw_pend_d   = aw_pend_q;
        outst_cnt_d = outst_cnt_q;
        fifo_d      = fifo_q;
        err_acc_d   = err_acc_q;
        tx_done_d   = 1'b0;
        tx_err_d    = 1'b0;

        if (m_arready) ar_pend_d = 1'b0;
        if (m_awready) aw_pend_d = 1'b0;

        if (accept) begin
            arid_d    = arid;
            araddr_d  = araddr;
            arlen_d   = arlen;
            arburst_d = arburst;
            ar_pend_d = 1'b1;
            awid_d    = awid;
            awaddr_d  = awaddr;
            awlen_d   = awlen;
            awburst_d = awburst;
            aw_pend_d = 1'b1;
        end

        if (b_hs) begin
            fifo_d = fifo_q >> 1;
            if (fifo_q[0]) begin
                tx_done_d = 1'b1;
                tx_err_d  = err_e;
                err_acc_d = 1'b0;
            end else begin
                err_acc_d = err_e;
            end
        end

        if (accept) fifo_d[push_idx] = atx_last;

        if (accept && !b_hs)      outst_cnt_d = outst_cnt_q + 1'b1;
        else if (!accept && b_hs) outst_cnt_d = outst_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arburst_q   <= '0;
            ar_pend_q   <= 1'b0;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awburst_q   <= '0;
            aw_pend_q   <= 1'b0;
            outst_cnt_q <= '0;
            fifo_q      <= '0;
            err_acc_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arburst_q   <= arburst_d;
            ar_pend_q   <= ar_pend_d;
            awid_q      <= awid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awburst_q   <= awburst_d;
            aw_pend_q   <= aw_pend_d;
            outst_cnt_q <= outst_cnt_d;
            fifo_q      <= fifo_d;
            err_acc_q   <= err_acc_d;
            tx_done_q   <= tx_done_d;
            tx_err_q    <= tx_err_d;
        end
    end

    assign m_arid    = arid_q;
    assign m_araddr  = araddr_q;
    assign m_arlen   = arlen_q;
    assign m_arburst = arburst_q;
    assign m_arvalid = ar_pend_q;
    assign m_awid    = awid_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awburst = awburst_q;
    assign m_awvalid = aw_pend_q;
    assign tx_done   = tx_done_q;
    assign tx_err    = tx_err_q;

endmodule

// File: tb/tb_adma_as_atx_dispatch.sv
// Bench for adma_as_atx_dispatch: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_adma_as_atx_dispatch;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, awburst;
    logic        atx_last, atx_vld, atx_rdy;
    logic [4:0]  m_arid, m_awid;
    logic [31:0] m_araddr, m_awaddr;
    logic [7:0]  m_arlen, m_awlen;
    logic [1:0]  m_arburst, m_awburst;
    logic        m_arvalid, m_arready, m_awvalid, m_awready;
    logic [1:0]  m_bresp;
    logic        m_bvalid, m_bready;
    logic        tx_done, tx_err;

    adma_as_atx_dispatch dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .atx_last(atx_last), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the master channels should be showing, the
    // ordered list of last-flags for bursts still awaiting B, and the
    // completion expected after the most recent edge.
    bit          mar_v, maw_v;
    logic [4:0]  e_arid, e_awid;
    logic [31:0] e_araddr, e_awaddr;
    logic [7:0]  e_arlen, e_awlen;
    logic [1:0]  e_arburst, e_awburst;
    bit          lastq[$];
    bit          m_err_acc;
    bit          e_done, e_err;
    int          dut_acc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mar_v = 0; maw_v = 0;
        e_arid = '0; e_araddr = '0; e_arlen = '0; e_arburst = '0;
        e_awid = '0; e_awaddr = '0; e_awlen = '0; e_awburst = '0;
        lastq.delete();
        m_err_acc = 0; e_done = 0; e_err = 0;
    endtask

    // Compare at the falling edge (inputs already settled), advance the
    // model to what the next rising edge must produce, then return just
    // after that edge so callers can inspect registered outputs.
    task automatic step();
        bit rdy_m, acc, bhs, f, e;
        @(negedge clk); #1;
        rdy_m = (!mar_v || m_arready) && (!maw_v || m_awready) && (lastq.size() < MAXO);
        chk("atx_rdy",   atx_rdy,   rdy_m);
        chk("m_bready",  m_bready,  lastq.size() != 0);
        chk("m_arvalid", m_arvalid, mar_v);
        chk("m_awvalid", m_awvalid, maw_v);
        chk("ar_payload", {m_arid, m_araddr, m_arlen, m_arburst}, {e_arid, e_araddr, e_arlen, e_arburst});
        chk("aw_payload", {m_awid, m_awaddr, m_awlen, m_awburst}, {e_awid, e_awaddr, e_awlen, e_awburst});
        chk("tx_done",   tx_done,   e_done);
        if (e_done) chk("tx_err", tx_err, e_err);
        if (atx_vld && atx_rdy && !rst) dut_acc++;

        if (rst) begin
            model_reset();
        end else begin
            acc = atx_vld && rdy_m;
            bhs = m_bvalid && (lastq.size() != 0);
            if (acc) begin
                mar_v = 1; e_arid = arid; e_araddr = araddr; e_arlen = arlen; e_arburst = arburst;
                maw_v = 1; e_awid = awid; e_awaddr = awaddr; e_awlen = awlen; e_awburst = awburst;
            end else begin
                if (m_arready) mar_v = 0;
                if (m_awready) maw_v = 0;
            end
            e_done = 0; e_err = 0;
            if (bhs) begin
                f = lastq.pop_front();
                e = m_err_acc | m_bresp[1];
                if (f) begin
                    e_done = 1; e_err = e; m_err_acc = 0;
                end else begin
                    m_err_acc = e;
                end
            end
            if (acc) lastq.push_back(atx_last);
        end
        @(posedge clk); #1;
    endtask

    task automatic set_desc(input logic [31:0] sa, input logic [31:0] da, input logic [7:0] len, input logic last);
        arid = 5'd1; araddr = sa; arlen = len; arburst = 2'b01;
        awid = 5'd2; awaddr = da; awlen = len; awburst = 2'b01;
        atx_last = last;
    endtask

    task automatic drain();
        atx_vld = 0; m_arready = 1; m_awready = 1; m_bvalid = 1; m_bresp = 2'b00;
        for (int i = 0; i < 40; i++) begin
            if (lastq.size() == 0 && !mar_v && !maw_v) break;
            step();
        end
        m_bvalid = 0;
        step();
        chk("drain_idle", {m_bready, m_arvalid, m_awvalid}, 3'b000);
    endtask

    initial begin
        int dc;
        logic es;
        logic [1:0] resp_seq [3];
        rst = 1; atx_vld = 0; m_arready = 1; m_awready = 1; m_bvalid = 0; m_bresp = 0;
        set_desc(32'h0, 32'h0, 8'h0, 1'b0);
        model_reset();
        @(posedge clk); #1;
        step();
        rst = 0;
        chk("reset_rdy", atx_rdy, 1);
        chk("reset_valids", {m_arvalid, m_awvalid, tx_done}, 3'b000);

        // single burst
        set_desc(32'h1000, 32'h2000, 8'd3, 1'b1);
        atx_vld = 1;
        step();
        atx_vld = 0;
        chk("single_arvalid", m_arvalid, 1);
        chk("single_araddr", m_araddr, 32'h1000);
        chk("single_awaddr", m_awaddr, 32'h2000);
        chk("single_len", {m_arlen, m_awlen}, 16'h0303);
        step();
        chk("single_valid_drop", {m_arvalid, m_awvalid}, 2'b00);
        m_bvalid = 1; m_bresp = 2'b00;
        step();
        m_bvalid = 0;
        chk("single_done", {tx_done, tx_err}, 2'b10);
        step();
        chk("single_done_pulse", tx_done, 0);

        // AR/AW skew
        m_awready = 0;
        set_desc(32'h3000, 32'h4000, 8'd7, 1'b1);
        atx_vld = 1;
        step();
        set_desc(32'h5000, 32'h6000, 8'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("skew_rdy", atx_rdy, 0);
            chk("skew_ar_done", m_arvalid, 0);
            chk("skew_aw_hold", {m_awvalid, m_awaddr}, {1'b1, 32'h4000});
        end
        m_awready = 1;
        step();
        atx_vld = 0;
        drain();

        // outstanding limit
        dut_acc = 0;
        atx_vld = 1;
        for (int i = 0; i < 6; i++) begin
            set_desc(32'h100 * i, 32'h8000 + 32'h100 * i, 8'(i), 1'(i % 2));
            step();
        end
        chk("limit_accepts", dut_acc, 4);
        m_bvalid = 1;
        step();
        m_bvalid = 0;
        for (int i = 0; i < 3; i++) step();
        chk("limit_one_more", dut_acc, 5);

        // accept and B together at the limit boundary; order checked by model
        m_bvalid = 1;
        for (int i = 0; i < 8; i++) begin
            set_desc(32'hA000 + i, 32'hB000 + i, 8'(i), 1'(i % 3 == 0));
            m_bresp = (i == 2) ? 2'b10 : 2'b00;
            step();
        end
        drain();

        // error accumulation
        atx_vld = 1;
        set_desc(32'h10, 32'h20, 8'd0, 1'b0); step();
        set_desc(32'h11, 32'h21, 8'd0, 1'b0); step();
        set_desc(32'h12, 32'h22, 8'd0, 1'b1); step();
        atx_vld = 0;
        step();
        resp_seq[0] = 2'b00; resp_seq[1] = 2'b10; resp_seq[2] = 2'b00;
        dc = 0; es = 0;
        m_bvalid = 1;
        for (int i = 0; i < 3; i++) begin
            m_bresp = resp_seq[i];
            step();
            if (tx_done) begin dc++; es = tx_err; end
        end
        m_bvalid = 0;
        chk("err_done_count", dc, 1);
        chk("err_tx_err", es, 1);
        atx_vld = 1;
        set_desc(32'h13, 32'h23, 8'd2, 1'b1); step();
        atx_vld = 0;
        step();
        m_bvalid = 1; m_bresp = 2'b00;
        step();
        m_bvalid = 0;
        chk("err_clear", {tx_done, tx_err}, 2'b10);
        step();

        // reset mid-operation
        atx_vld = 1;
        set_desc(32'hC000, 32'hD000, 8'd4, 1'b1); step();
        set_desc(32'hC100, 32'hD100, 8'd4, 1'b1); step();
        atx_vld = 0; m_awready = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_valids", {m_arvalid, m_awvalid}, 2'b00);
        chk("rst_rdy", atx_rdy, 1);
        chk("rst_bready", m_bready, 0);
        m_awready = 1; m_bvalid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_done", tx_done, 0);
        end
        m_bvalid = 0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            atx_vld   = $urandom_range(0, 1);
            arid      = 5'($urandom); araddr = $urandom; arlen = 8'($urandom); arburst = 2'($urandom);
            awid      = 5'($urandom); awaddr = $urandom; awlen = 8'($urandom); awburst = 2'($urandom);
            atx_last  = ($urandom_range(0, 2) == 0);
            m_arready = ($urandom_range(0, 3) != 0);
            m_awready = ($urandom_range(0, 3) != 0);
            m_bvalid  = ($urandom_range(0, 2) != 0);
            m_bresp   = 2'($urandom);
            step();
        end
        rst = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
